// File: rtl/rvm_trap_ctrl_if.sv
// rvm_trap_ctrl_if: trap capture strobe toward the SCU and PC redirect handshake toward the PCU
//   trap_wr        : one-cycle strobe, SCU loads mepc/mcause/mtval
//   trap_epc/cause/tval : capture values, valid while trap_wr
//   redirect_valid/redirect_pc/redirect_ready : PCU redirect handshake
interface rvm_trap_ctrl_if;
  logic        trap_wr;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  modport master (
    output trap_wr, trap_epc, trap_cause, trap_tval, redirect_valid, redirect_pc,
    input  redirect_ready
  );
  modport slave (
    input  trap_wr, trap_epc, trap_cause, trap_tval, redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/rvm_trap_ctrl.sv
// rvm_trap_ctrl: trap entry/exit sequencer arbitrating exceptions, interrupts and mret
//   clk, resetn (async, active-low)
//   core_stall_i, instr_boundary_i, pc_i, next_pc_i, exc_vec_i, exc_tval_i : core event inputs
//   irq_pending_i/irq_enable_i {mei, mti, msi}, mret_i, mtvec_i, mepc_in_i
//   mstatus_wr_i/mstatus_wdata_i {mpie, mie} : CSR write to mstatus
//   mstatus_mie_o, mstatus_mpie_o, busy_o
//   bus : trap capture strobe and PCU redirect handshake
module rvm_trap_ctrl #(
  parameter int MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_stall_i,
  input  logic        instr_boundary_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] next_pc_i,
  input  logic [7:0]  exc_vec_i,
  input  logic [31:0] exc_tval_i,
  input  logic [2:0]  irq_pending_i,
  input  logic [2:0]  irq_enable_i,
  input  logic        mret_i,
  input  logic [29:0] mtvec_i,
  input  logic [31:0] mepc_in_i,
  input  logic        mstatus_wr_i,
  input  logic [1:0]  mstatus_wdata_i,
  output logic        mstatus_mie_o,
  output logic        mstatus_mpie_o,
  output logic        busy_o,
  rvm_trap_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ENTER, RETURN, REDIRECT} state_e;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << MTVEC_ALIGN) - 32'd1);
  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d, rpc_q, rpc_d;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [2:0]  irq_en, exc_idx;
  logic [3:0]  irq_code;
  logic        sample, take_exc, take_irq, take_mret;
  // lowest set bit wins: scan from the top so lower indices overwrite
  always_comb begin
    exc_idx = '0;
    for (int i = 7; i >= 0; i--) if (exc_vec_i[i]) exc_idx = 3'(i);
  end
  assign irq_en    = irq_pending_i & irq_enable_i;
  assign irq_code  = irq_en[2] ? 4'd11 : irq_en[0] ? 4'd3 : 4'd7;
  assign sample    = state_q == IDLE && !core_stall_i;
  assign take_exc  = sample && |exc_vec_i;
  assign take_irq  = sample && !take_exc && instr_boundary_i && mie_q && |irq_en;
  assign take_mret = sample && !take_exc && !take_irq && instr_boundary_i && mret_i;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    rpc_d   = rpc_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    case (state_q)
      IDLE: begin
        if (take_exc || take_irq) begin
          state_d = ENTER;
          cause_d = take_exc ? {29'd0, exc_idx} : {1'b1, 27'd0, irq_code};
          epc_d   = take_exc ? pc_i : next_pc_i;
          tval_d  = take_exc ? exc_tval_i : '0;
          // mtvec is captured now since inputs are ignored once the sequence starts
          rpc_d   = {mtvec_i, 2'b00} & ALIGN_MASK;
        end else if (take_mret) begin
          state_d = RETURN;
        end else if (mstatus_wr_i) begin
          {mpie_d, mie_d} = mstatus_wdata_i;
        end
      end
      ENTER: begin
        state_d = REDIRECT;
        mpie_d  = mie_q;
        mie_d   = 1'b0;
      end
      RETURN: begin
        state_d = REDIRECT;
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        rpc_d   = mepc_in_i;
      end
      REDIRECT: state_d = bus.redirect_ready ? IDLE : REDIRECT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      rpc_q   <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      rpc_q   <= rpc_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
    end
  end
  assign bus.trap_wr        = state_q == ENTER;
  assign bus.trap_epc       = epc_q;
  assign bus.trap_cause     = cause_q;
  assign bus.trap_tval      = tval_q;
  assign bus.redirect_valid = state_q == REDIRECT;
  assign bus.redirect_pc    = rpc_q;
  assign busy_o             = state_q != IDLE;
  assign mstatus_mie_o      = mie_q;
  assign mstatus_mpie_o     = mpie_q;
endmodule

// File: doc/rvm_trap_ctrl.md
# rvm_trap_ctrl

Trap entry/exit sequencer for the multi-cycle core. It sits between the decode/execute control, the SCU and the PCU. It arbitrates between synchronous exceptions, enabled pending interrupts and `mret`, and owns the `mstatus` MIE/MPIE bits. For each event it produces a one-cycle CSR capture strobe toward the SCU and a valid/ready PC redirect toward the PCU.

## Interface
Parameters:
- `MTVEC_ALIGN`, default 2. Low bits of `redirect_pc` forced to zero on trap entry.

Ports:
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `core_stall` in 1: no event is sampled while high.
- `instr_boundary` in 1: the current instruction completes this cycle.
- `pc` in 32: address of the current instruction.
- `next_pc` in 32: address of the next sequential or branch-target instruction.
- `exc_vec` in 8: exceptions of the current instruction. Bit i gives cause i (0 iaddr_misalign … 7 saddr_fault).
- `exc_tval` in 32: bad address/value for the exception.
- `irq_pending` in 3: {mei, mti, msi}.
- `irq_enable` in 3: {meie, mtie, msie}.
- `mret` in 1: the current instruction is MRET.
- `mtvec` in 30: trap vector [31:2].
- `mepc_in` in 32: current SCU mepc, used for return.
- `mstatus_wr` in 1: CSR write to mstatus.
- `mstatus_wdata` in 2: {mpie, mie}.
- `trap_wr` out 1: one-cycle strobe; SCU loads mepc/mcause/mtval.
- `trap_epc` out 32, `trap_cause` out 32, `trap_tval` out 32: capture values, valid while `trap_wr`.
- `mstatus_mie` out 1, `mstatus_mpie` out 1.
- `redirect_valid` out 1, `redirect_pc` out 32, `redirect_ready` in 1: PCU handshake.
- `busy` out 1: high whenever the block is not in IDLE; the core holds fetch/issue.

## Operation
- States: IDLE, ENTER, RETURN, REDIRECT.
- IDLE sampling happens only when `core_stall`=0.
  - Exception: `exc_vec`≠0, sampled regardless of `instr_boundary`.
  - Interrupt: `instr_boundary` & `mstatus_mie` & |(`irq_pending` & `irq_enable`).
  - MRET: `instr_boundary` & `mret`.
- Event priority: exception > interrupt > mret. At most one event is accepted per sample.
- Exception cause is the lowest set bit index of `exc_vec`.
  - cause = {1'b0, 27'b0, idx}, epc = `pc`, tval = `exc_tval`.
- Interrupt priority among enabled pending sources: MEI(11) > MSI(3) > MTI(7).
  - cause = {1'b1, 31'(code)}, epc = `next_pc`, tval = 0.
- IDLE→ENTER on exception or interrupt. Cause, epc and tval are registered on the transition.
- ENTER lasts 1 cycle.
  - `trap_wr`=1.
  - mpie←mie, mie←0.
  - Then →REDIRECT with `redirect_pc` = {mtvec, 2'b00}, with the low `MTVEC_ALIGN` bits zero.
- IDLE→RETURN on mret. RETURN lasts 1 cycle.
  - mie←mpie, mpie←1.
  - `redirect_pc` = `mepc_in` sampled in RETURN.
  - Then →REDIRECT.
- REDIRECT: `redirect_valid`=1. `redirect_pc` stays stable until `redirect_valid`&`redirect_ready`, then →IDLE.
- `mstatus_wr` is accepted only in IDLE, and only when no event is accepted in the same cycle; if an event is accepted, the event wins and the write is dropped. `mstatus_wr` is ignored in other states.
- All inputs except `redirect_ready` and `mepc_in` are ignored outside IDLE.

## Timing
- Reset (async): state IDLE; all outputs 0, including `mstatus_mie` and `mstatus_mpie`.
- Reset asserted mid-sequence: outputs clear immediately, with no pending redirect or strobe.
- Trap entry, event sampled in cycle N:
  - `busy` from N+1.
  - `trap_wr` in N+1.
  - `mstatus_mie`=0 visible from N+2.
  - `redirect_valid` from N+2.
- MRET, sampled in cycle N:
  - RETURN in N+1.
  - `redirect_valid` from N+2.
  - mstatus update visible from N+2.
- Handshake completing in cycle M: `redirect_valid`=0 and `busy`=0 from M+1.
  - Minimum event-to-IDLE time is 3 cycles.
  - The next event can be sampled in M+1.
- `redirect_ready` high before valid has no effect.
- `trap_wr` is never asserted in two consecutive cycles.
- `busy` is registered (state≠IDLE), not combinational from the inputs.

## Test plan
- Illegal instruction: `exc_vec`=0x04, `pc`=0x100, `mtvec`=0x070, `redirect_ready` low for 3 cycles.
  - `trap_wr` at N+1 with cause=2, epc=0x100.
  - `redirect_valid` held for 4 cycles with `redirect_pc`=0x1C0.
  - `busy` drops the cycle after the handshake.
- Multiple exceptions: `exc_vec`=0x30 with `irq_pending`=7, all enabled, mie=1.
  - Cause=4, tval=`exc_tval`; no interrupt is taken.
- Interrupt: mie=1, `irq_pending`=3'b110, `irq_enable`=3'b111, `instr_boundary`=1, `next_pc`=0x204.
  - Cause=0x8000000B, epc=0x204.
  - mie→0, mpie→1.
  - A repeat of the same stimulus in IDLE takes no trap (mie=0).
- Interrupt masking:
  - With mie=0, pending MTI → no trap.
  - With `core_stall`=1, exception → no trap until stall releases, then cause taken.
- MRET with mpie=1, mie=0, `mepc_in`=0x300.
  - `redirect_pc`=0x300, mie=1, mpie=1, `trap_wr` never asserted.
  - `mstatus_wr` in the same cycle is dropped.
- Reset: assert `resetn`=0 during REDIRECT.
  - `redirect_valid`, `busy`, `mstatus_mie` and `mstatus_mpie` = 0 immediately.
  - After release, an exception is sampled normally.
